// File: rtl/irq_timer_ctrl.sv
// Machine timer (mtime/mtimecmp) plus external interrupt line, arbitrated into a
// single-cycle trap request for the 3-stage RV32 core, with handshake on handler return.
module irq_timer_ctrl #(
   parameter int PRESCALE = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        bus_sel,
   input  logic [3:0]  bus_addr,
   input  logic        bus_we,
   input  logic [31:0] bus_wdata,
   output logic [31:0] bus_rdata,
   input  logic        ext_irq,
   input  logic        irq_done,
   output logic        interrupt_exception,
   output logic [1:0]  irq_cause
);

   localparam logic [3:0] ADDR_MTIME    = 4'h0;
   localparam logic [3:0] ADDR_MTIMECMP = 4'h4;
   localparam logic [3:0] ADDR_CTRL     = 4'h8;
   localparam logic [3:0] ADDR_STATUS   = 4'hC;

   localparam logic [1:0] CAUSE_NONE  = 2'b00;
   localparam logic [1:0] CAUSE_TIMER = 2'b01;
   localparam logic [1:0] CAUSE_EXT   = 2'b10;

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_REQ     = 2'd1,
      S_SERVICE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [31:0]   mtime_q, mtime_d;
   logic [31:0]   mtimecmp_q, mtimecmp_d;
   logic [1:0]    ctrl_q, ctrl_d;
   logic          timer_pend_q, timer_pend_d;
   logic          ext_pend_q, ext_pend_d;
   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic          sync3_q, sync3_d;
   logic [1:0]    cause_q, cause_d;

   logic wr_en;
   logic wr_mtime;
   logic wr_mtimecmp;
   logic wr_ctrl;
   logic wr_status;
   logic tick;
   logic ext_edge;
   logic ext_set;
   logic ext_clr;
   logic ext_req;
   logic any_req;

   always_comb begin
      wr_en       = bus_sel && bus_we;
      wr_mtime    = wr_en && (bus_addr == ADDR_MTIME);
      wr_mtimecmp = wr_en && (bus_addr == ADDR_MTIMECMP);
      wr_ctrl     = wr_en && (bus_addr == ADDR_CTRL);
      wr_status   = wr_en && (bus_addr == ADDR_STATUS);
   end

   // Timer: a write to either timer register suppresses the increment of that cycle.
   always_comb begin
      tick       = (presc_q == PRESC_MAX);
      presc_d    = tick ? '0 : presc_q + PW'(1);
      mtime_d    = mtime_q;
      mtimecmp_d = mtimecmp_q;
      if (wr_mtime) begin
         mtime_d = bus_wdata;
      end else if (tick && !wr_mtimecmp) begin
         mtime_d = mtime_q + 32'd1;
      end
      if (wr_mtimecmp) begin
         mtimecmp_d = bus_wdata;
      end
      ctrl_d       = wr_ctrl ? bus_wdata[1:0] : ctrl_q;
      timer_pend_d = ctrl_q[0] && (mtime_q >= mtimecmp_q);
   end

   always_comb begin
      sync1_d  = ext_irq;
      sync2_d  = sync1_q;
      sync3_d  = sync2_q;
      ext_edge = sync2_q && !sync3_q;
      ext_set  = ext_edge && ctrl_q[1];
      ext_clr  = wr_status && bus_wdata[1];
      ext_pend_d = ext_pend_q;
      if (ext_set) begin
         ext_pend_d = 1'b1;
      end else if (ext_clr) begin
         ext_pend_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         presc_q      <= '0;
         mtime_q      <= 32'd0;
         mtimecmp_q   <= 32'hFFFF_FFFF;
         ctrl_q       <= 2'b00;
         timer_pend_q <= 1'b0;
         ext_pend_q   <= 1'b0;
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         sync3_q      <= 1'b0;
      end else begin
         presc_q      <= presc_d;
         mtime_q      <= mtime_d;
         mtimecmp_q   <= mtimecmp_d;
         ctrl_q       <= ctrl_d;
         timer_pend_q <= timer_pend_d;
         ext_pend_q   <= ext_pend_d;
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         sync3_q      <= sync3_d;
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cause_q <= CAUSE_NONE;
      end else begin
         state_q <= state_d;
         cause_q <= cause_d;
      end
   end

   // FSM next state; cause is captured on leaving IDLE so the handler sees a stable value.
   always_comb begin
      ext_req = ext_pend_q && ctrl_q[1];
      any_req = ext_req || timer_pend_q;
      state_d = state_q;
      cause_d = cause_q;
      case (state_q)
         S_IDLE: begin
            if (any_req) begin
               state_d = S_REQ;
               cause_d = ext_req ? CAUSE_EXT : CAUSE_TIMER;
            end
         end
         S_REQ: begin
            state_d = S_SERVICE;
         end
         S_SERVICE: begin
            if (irq_done) begin
               state_d = S_IDLE;
               cause_d = CAUSE_NONE;
            end
         end
         default: begin
            state_d = S_IDLE;
            cause_d = CAUSE_NONE;
         end
      endcase
   end

   // FSM outputs: the trap request is a single-cycle pulse so the PC is redirected once.
   always_comb begin
      interrupt_exception = (state_q == S_REQ);
      irq_cause           = cause_q;
   end

   always_comb begin
      case (bus_addr)
         ADDR_MTIME:    bus_rdata = mtime_q;
         ADDR_MTIMECMP: bus_rdata = mtimecmp_q;
         ADDR_CTRL:     bus_rdata = {30'd0, ctrl_q};
         ADDR_STATUS:   bus_rdata = {30'd0, ext_pend_q, timer_pend_q};
         default:       bus_rdata = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_irq_timer_ctrl.sv
// Directed self-checking bench for irq_timer_ctrl (PRESCALE=1).
module tb_irq_timer_ctrl;

   localparam logic [3:0] A_MTIME  = 4'h0;
   localparam logic [3:0] A_CMP    = 4'h4;
   localparam logic [3:0] A_CTRL   = 4'h8;
   localparam logic [3:0] A_STATUS = 4'hC;

   logic        clk;
   logic        rst;
   logic        bus_sel;
   logic [3:0]  bus_addr;
   logic        bus_we;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        ext_irq;
   logic        irq_done;
   logic        interrupt_exception;
   logic [1:0]  irq_cause;

   int tests_run;
   int tests_failed;

   irq_timer_ctrl #(.PRESCALE(1)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .bus_sel             (bus_sel),
      .bus_addr            (bus_addr),
      .bus_we              (bus_we),
      .bus_wdata           (bus_wdata),
      .bus_rdata           (bus_rdata),
      .ext_irq             (ext_irq),
      .irq_done            (irq_done),
      .interrupt_exception (interrupt_exception),
      .irq_cause           (irq_cause)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // All tasks are entered at a negedge and return at a negedge.
   task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
      bus_sel = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
      @(negedge clk);
      bus_sel = 1'b0; bus_we = 1'b0; bus_wdata = 32'd0;
   endtask

   task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
      bus_addr = a;
      #1;
      d = bus_rdata;
   endtask

   task automatic pulse_done();
      irq_done = 1'b1;
      @(negedge clk);
      irq_done = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      rst = 1'b0; ext_irq = 1'b1;
      @(negedge clk);
      bus_write(A_CTRL, 32'd1);
      idle(3);
      tests_run++;
      if (interrupt_exception !== 1'b0) begin tests_failed++; $display("FAIL reset_irq: got %b want 0", interrupt_exception); end
      tests_run++;
      if (irq_cause !== 2'b00) begin tests_failed++; $display("FAIL reset_cause: got %b want 00", irq_cause); end
      bus_read(A_CMP, rd);
      tests_run++;
      if (rd !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL reset_mtimecmp: got %h want ffffffff", rd); end
      bus_read(A_MTIME, rd);
      tests_run++;
      if (rd !== 32'd0) begin tests_failed++; $display("FAIL reset_mtime: got %h want 0", rd); end
      bus_read(A_CTRL, rd);
      tests_run++;
      if (rd !== 32'd0) begin tests_failed++; $display("FAIL reset_ctrl: got %h want 0", rd); end
      bus_read(A_STATUS, rd);
      tests_run++;
      if (rd !== 32'd0) begin tests_failed++; $display("FAIL reset_status: got %h want 0", rd); end
      bus_read(4'h2, rd);
      tests_run++;
      if (rd !== 32'd0) begin tests_failed++; $display("FAIL reset_unmapped: got %h want 0", rd); end
      @(negedge clk);
      ext_irq = 1'b0; rst = 1'b1;
      idle(4);
   endtask

   task automatic test_timer();
      logic [31:0] rd;
      int found;
      int seen;
      bus_write(A_MTIME, 32'd0);
      bus_write(A_CMP, 32'd10);
      bus_write(A_CTRL, 32'd1);
      found = 0;
      for (int i = 0; i < 40; i++) begin
         if (interrupt_exception === 1'b1) begin found = 1; break; end
         @(negedge clk);
      end
      tests_run++;
      if (found !== 1) begin tests_failed++; $display("FAIL timer_pulse_seen: got %0d want 1", found); end
      bus_read(A_MTIME, rd);
      tests_run++;
      if (rd !== 32'd12) begin tests_failed++; $display("FAIL timer_latency_mtime: got %0d want 12", rd); end
      tests_run++;
      if (irq_cause !== 2'b01) begin tests_failed++; $display("FAIL timer_cause: got %b want 01", irq_cause); end
      @(negedge clk);
      tests_run++;
      if (interrupt_exception !== 1'b0) begin tests_failed++; $display("FAIL timer_pulse_width: got %b want 0", interrupt_exception); end
      tests_run++;
      if (irq_cause !== 2'b01) begin tests_failed++; $display("FAIL timer_cause_held: got %b want 01", irq_cause); end
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (interrupt_exception) seen++;
      end
      tests_run++;
      if (seen !== 0) begin tests_failed++; $display("FAIL timer_no_second_pulse: got %0d pulses want 0", seen); end
      pulse_done();
      tests_run++;
      if (interrupt_exception !== 1'b0 || irq_cause !== 2'b00) begin
         tests_failed++; $display("FAIL timer_idle_gap: got irq=%b cause=%b want 0/00", interrupt_exception, irq_cause);
      end
      @(negedge clk);
      tests_run++;
      if (interrupt_exception !== 1'b1 || irq_cause !== 2'b01) begin
         tests_failed++; $display("FAIL timer_rerequest: got irq=%b cause=%b want 1/01", interrupt_exception, irq_cause);
      end
      bus_write(A_CMP, 32'hFFFF_FFFF);
      idle(3);
      pulse_done();
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (interrupt_exception) seen++;
      end
      tests_run++;
      if (seen !== 0) begin tests_failed++; $display("FAIL timer_cleared: got %0d pulses want 0", seen); end
      bus_read(A_STATUS, rd);
      tests_run++;
      if (rd !== 32'd0) begin tests_failed++; $display("FAIL timer_status_cleared: got %h want 0", rd); end
      bus_write(A_CTRL, 32'd0);
      idle(3);
   endtask

   task automatic test_external();
      logic [31:0] rd;
      int seen;
      bus_write(A_CTRL, 32'd2);
      ext_irq = 1'b1;
      idle(3);
      bus_read(A_STATUS, rd);
      tests_run++;
      if (rd !== 32'd2 || interrupt_exception !== 1'b0) begin
         tests_failed++; $display("FAIL ext_pend_timing: got status=%h irq=%b want 2/0", rd, interrupt_exception);
      end
      @(negedge clk);
      tests_run++;
      if (interrupt_exception !== 1'b1 || irq_cause !== 2'b10) begin
         tests_failed++; $display("FAIL ext_pulse: got irq=%b cause=%b want 1/10", interrupt_exception, irq_cause);
      end
      @(negedge clk);
      tests_run++;
      if (interrupt_exception !== 1'b0) begin tests_failed++; $display("FAIL ext_pulse_width: got %b want 0", interrupt_exception); end
      bus_write(A_STATUS, 32'd2);
      bus_read(A_STATUS, rd);
      tests_run++;
      if (rd !== 32'd0) begin tests_failed++; $display("FAIL ext_w1c: got %h want 0", rd); end
      pulse_done();
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (interrupt_exception) seen++;
      end
      tests_run++;
      if (seen !== 0) begin tests_failed++; $display("FAIL ext_level_no_event: got %0d pulses want 0", seen); end
      ext_irq = 1'b0;
      bus_write(A_CTRL, 32'd0);
      idle(3);
   endtask

   task automatic test_priority();
      logic [31:0] rd;
      bus_write(A_CMP, 32'd0);
      ext_irq = 1'b1;
      @(negedge clk);
      bus_write(A_CTRL, 32'd3);
      @(negedge clk);
      bus_read(A_STATUS, rd);
      tests_run++;
      if (rd !== 32'd3 || interrupt_exception !== 1'b0) begin
         tests_failed++; $display("FAIL prio_both_pending: got status=%h irq=%b want 3/0", rd, interrupt_exception);
      end
      @(negedge clk);
      tests_run++;
      if (interrupt_exception !== 1'b1 || irq_cause !== 2'b10) begin
         tests_failed++; $display("FAIL prio_ext_first: got irq=%b cause=%b want 1/10", interrupt_exception, irq_cause);
      end
      bus_write(A_STATUS, 32'd2);
      pulse_done();
      bus_read(A_STATUS, rd);
      tests_run++;
      if (rd !== 32'd1 || interrupt_exception !== 1'b0 || irq_cause !== 2'b00) begin
         tests_failed++; $display("FAIL prio_after_done: got status=%h irq=%b cause=%b want 1/0/00", rd, interrupt_exception, irq_cause);
      end
      @(negedge clk);
      tests_run++;
      if (interrupt_exception !== 1'b1 || irq_cause !== 2'b01) begin
         tests_failed++; $display("FAIL prio_timer_second: got irq=%b cause=%b want 1/01", interrupt_exception, irq_cause);
      end
      bus_write(A_CMP, 32'hFFFF_FFFF);
      idle(3);
      pulse_done();
      ext_irq = 1'b0;
      bus_write(A_CTRL, 32'd0);
      idle(4);
   endtask

   task automatic test_edges();
      logic [31:0] rd;
      bus_write(A_MTIME, 32'hFFFF_FFFF);
      bus_read(A_MTIME, rd);
      tests_run++;
      if (rd !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL edge_mtime_written: got %h want ffffffff", rd); end
      @(negedge clk);
      bus_read(A_MTIME, rd);
      tests_run++;
      if (rd !== 32'd0) begin tests_failed++; $display("FAIL edge_mtime_wrap: got %h want 0", rd); end
      bus_write(A_MTIME, 32'd100);
      bus_read(A_MTIME, rd);
      tests_run++;
      if (rd !== 32'd100) begin tests_failed++; $display("FAIL edge_write_beats_tick: got %0d want 100", rd); end
      @(negedge clk);
      bus_read(A_MTIME, rd);
      tests_run++;
      if (rd !== 32'd101) begin tests_failed++; $display("FAIL edge_tick_after_write: got %0d want 101", rd); end
      bus_write(A_CTRL, 32'hFFFF_FFFC);
      bus_read(A_CTRL, rd);
      tests_run++;
      if (rd !== 32'd0) begin tests_failed++; $display("FAIL edge_ctrl_upper_bits: got %h want 0", rd); end
      bus_write(A_CTRL, 32'd2);
      ext_irq = 1'b1;
      idle(2);
      bus_write(A_STATUS, 32'd2);
      bus_read(A_STATUS, rd);
      tests_run++;
      if (rd !== 32'd2) begin tests_failed++; $display("FAIL edge_set_beats_w1c: got status=%h want 2", rd); end
      @(negedge clk);
      tests_run++;
      if (interrupt_exception !== 1'b1 || irq_cause !== 2'b10) begin
         tests_failed++; $display("FAIL edge_set_request: got irq=%b cause=%b want 1/10", interrupt_exception, irq_cause);
      end
      bus_write(A_STATUS, 32'd2);
      pulse_done();
      ext_irq = 1'b0;
      bus_write(A_CTRL, 32'd0);
      idle(4);
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd;
      int found;
      int seen;
      bus_write(A_CMP, 32'd0);
      bus_write(A_CTRL, 32'd1);
      found = 0;
      for (int i = 0; i < 10; i++) begin
         if (interrupt_exception === 1'b1) begin found = 1; break; end
         @(negedge clk);
      end
      tests_run++;
      if (found !== 1) begin tests_failed++; $display("FAIL rmid_pulse_seen: got %0d want 1", found); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      tests_run++;
      if (interrupt_exception !== 1'b0 || irq_cause !== 2'b00) begin
         tests_failed++; $display("FAIL rmid_async_clear: got irq=%b cause=%b want 0/00", interrupt_exception, irq_cause);
      end
      bus_read(A_CMP, rd);
      tests_run++;
      if (rd !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL rmid_mtimecmp: got %h want ffffffff", rd); end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      pulse_done();
      seen = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (interrupt_exception || irq_cause !== 2'b00) seen++;
      end
      tests_run++;
      if (seen !== 0) begin tests_failed++; $display("FAIL rmid_done_ignored: got %0d bad cycles want 0", seen); end
      bus_write(A_CMP, 32'd0);
      bus_write(A_CTRL, 32'd1);
      @(negedge clk);
      tests_run++;
      if (interrupt_exception !== 1'b0) begin tests_failed++; $display("FAIL rmid_idle_wait: got %b want 0", interrupt_exception); end
      @(negedge clk);
      tests_run++;
      if (interrupt_exception !== 1'b1 || irq_cause !== 2'b01) begin
         tests_failed++; $display("FAIL rmid_back_in_idle: got irq=%b cause=%b want 1/01", interrupt_exception, irq_cause);
      end
      bus_write(A_CMP, 32'hFFFF_FFFF);
      bus_write(A_CTRL, 32'd0);
      idle(2);
      pulse_done();
      idle(2);
   endtask

   initial begin
      tests_run = 0; tests_failed = 0;
      rst = 1'b0; bus_sel = 1'b0; bus_addr = 4'h0; bus_we = 1'b0; bus_wdata = 32'd0;
      ext_irq = 1'b0; irq_done = 1'b0;
      test_reset();
      test_timer();
      test_external();
      test_priority();
      test_edges();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
